// File: rtl/register_file.sv
// Architectural register file x0..x31 with per-register ROB rename tags.
// Decoder issue renames rd; ROB commit writes values and retires matching tags.
`ifndef ROB_SIZE_BIT
`define ROB_SIZE_BIT 4
`endif

module register_file #(
    parameter int ROB_SIZE_BIT = `ROB_SIZE_BIT
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [4:0]              rob_set_idx,
    input  logic [31:0]             rob_set_reg_val,
    input  logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic [ROB_SIZE_BIT-1:0] issue_rob_idx,
    input  logic                    clear,
    input  logic [4:0]              query_rs1,
    output logic [31:0]             rs1_val,
    output logic                    rs1_has_dep,
    output logic [ROB_SIZE_BIT-1:0] rs1_dep,
    input  logic [4:0]              query_rs2,
    output logic [31:0]             rs2_val,
    output logic                    rs2_has_dep,
    output logic [ROB_SIZE_BIT-1:0] rs2_dep
);

    // Commit and issue are fire-and-forget: a request is taken whenever rdy_in is
    // high and clear is low; there is no ready/acknowledge path back to the ROB.
    logic [31:0]             r_regs      [32];
    logic [31:0]             r_dep_valid;
    logic [ROB_SIZE_BIT-1:0] r_dep       [32];

    logic w_live;
    logic w_commit;
    logic w_tag_match;
    logic w_issue;

    assign w_live      = rdy_in && !clear;
    assign w_commit    = rob_set_idx != 5'd0;
    assign w_tag_match = r_dep_valid[rob_set_idx] && (r_dep[rob_set_idx] == rob_set_recorder);
    assign w_issue     = issue_valid && (issue_rd != 5'd0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dep_valid <= '0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
                r_dep[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                r_dep_valid <= '0;
            end else begin
                if (w_commit) begin
                    r_regs[rob_set_idx] <= rob_set_reg_val;
                    if (w_tag_match) begin
                        r_dep_valid[rob_set_idx] <= 1'b0;
                    end
                end
                // Issue is placed last so a same-register rename overrides the retire.
                if (w_issue) begin
                    r_dep_valid[issue_rd] <= 1'b1;
                    r_dep[issue_rd]       <= issue_rob_idx;
                end
            end
        end
    end

    always_comb begin
        rs1_val     = r_regs[query_rs1];
        rs1_has_dep = r_dep_valid[query_rs1];
        rs1_dep     = r_dep[query_rs1];
        if (query_rs1 == 5'd0) begin
            rs1_val     = '0;
            rs1_has_dep = 1'b0;
            rs1_dep     = '0;
        end else if (w_live && w_commit && (rob_set_idx == query_rs1) && w_tag_match) begin
            rs1_val     = rob_set_reg_val;
            rs1_has_dep = 1'b0;
        end
    end

    always_comb begin
        rs2_val     = r_regs[query_rs2];
        rs2_has_dep = r_dep_valid[query_rs2];
        rs2_dep     = r_dep[query_rs2];
        if (query_rs2 == 5'd0) begin
            rs2_val     = '0;
            rs2_has_dep = 1'b0;
            rs2_dep     = '0;
        end else if (w_live && w_commit && (rob_set_idx == query_rs2) && w_tag_match) begin
            rs2_val     = rob_set_reg_val;
            rs2_has_dep = 1'b0;
        end
    end

endmodule
